cpu_mem_bridge: RTL and testbench
=================================

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: RAM word-address width (RAM depth 2^ADDR_WIDTH words).
REQ-002 SHALL have parameter RAM_LATENCY, default 2: RAM read latency in cycles (1..4).
REQ-003 SHALL have parameter MMIO_BASE, default 32'h8000_0000: byte addresses >= MMIO_BASE route to MMIO; below go to RAM.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: MMIO wait limit (used only when the timeout feature is compiled in).
REQ-005 SHALL have ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_mem_valid  in  1  CPU request.
- cpu_mem_addr  in  32  byte address.
- cpu_mem_wdata  in  32  write data.
- cpu_mem_wstrb  in  4  byte strobes; 0 = read.
- cpu_mem_ready  out  1  one-cycle completion pulse.
- cpu_mem_rdata  out  32  read data, valid with ready.
- flash_active  in  1  loader owns RAM port.
- flash_wen  in  1  loader write enable.
- flash_addr  in  ADDR_WIDTH  loader word address.
- flash_data  in  32  loader data.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_we  out  4  RAM byte write enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.
- mmio_valid  out  1  MMIO request.
- mmio_addr  out  32  MMIO byte address.
- mmio_wstrb  out  4  MMIO strobes.
- mmio_wdata  out  32  MMIO write data.
- mmio_ready  in  1  MMIO completion.
- mmio_rdata  in  32  MMIO read data.
- bus_error  out  1  sticky MMIO timeout flag.

Function
REQ-006 SHALL implement FSM IDLE, RAM_RD, RAM_WR, MMIO_WAIT, RESP; RESP always returns to IDLE.
REQ-007 In IDLE with cpu_mem_valid=1 and flash_active=0, SHALL latch address/data/strobes and branch on decode and wstrb.
REQ-008 RAM write: ram_we = cpu_mem_wstrb for exactly one cycle (native byte strobes, no read-modify-write); ready pulses the following cycle.
REQ-009 RAM read: ram_we=0; count RAM_LATENCY cycles from address issue, then register ram_rdata into cpu_mem_rdata and pulse ready.
REQ-010 RAM word index = cpu_mem_addr[ADDR_WIDTH+1:2]; higher bits ignored (wrap-around).
REQ-011 MMIO: mmio_valid held high with stable address/data/strobes until mmio_ready; capture mmio_rdata, drop valid, pulse ready next cycle.
REQ-012 cpu_mem_ready SHALL be high exactly one cycle per request; request acceptance resumes no earlier than the cycle after RESP.
REQ-013 While flash_active=1: ram_addr/ram_wdata/ram_we driven combinationally from flash_addr/flash_data/{4{flash_wen}}; no new CPU request accepted.
REQ-014 flash_active rising during RAM_RD or RAM_WR SHALL abort to IDLE without ready; CPU re-issue is served after flash_active falls. MMIO_WAIT is not aborted.
REQ-015 ram_we SHALL be 0 in every state other than RAM_WR when flash_active=0.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, cpu_mem_ready=0, cpu_mem_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, mmio_valid=0, mmio_addr=0, mmio_wstrb=0, mmio_wdata=0, bus_error=0, latency/timeout counters=0.
REQ-017 Reset mid-transaction SHALL discard it with no ready pulse and no RAM write.

Configuration
REQ-018 Macro MEM_BRIDGE_TIMEOUT_EN defined: MMIO_WAIT exceeding TIMEOUT_CYCLES cycles drops mmio_valid, returns rdata 32'hDEAD_BEEF with ready, sets bus_error (sticky until reset).
REQ-019 Macro undefined: MMIO_WAIT waits indefinitely; bus_error tied 0; no timeout counter synthesized.

Verification
REQ-020 Write addr 0x10, wdata 0xAABBCCDD, wstrb 0b0101 over word 0x11223344 -> ram_we=0101 one cycle; readback 0x11BB33DD.
REQ-021 Read with RAM_LATENCY=3 -> ready exactly 4 cycles after valid sampled in IDLE, rdata equals RAM content.
REQ-022 Read 0x8000_0004, mmio_ready after 5 cycles with 0x1234 -> mmio_valid 5 cycles, cpu_mem_rdata=0x1234, single ready pulse.
REQ-023 flash_active asserted during RAM_RD -> no ready, flash write to word 7 lands; after deassert re-issued read completes.
REQ-024 With MEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, mmio_ready held 0 -> ready with 0xDEADBEEF, bus_error=1 until rst_n low.
REQ-025 rst_n low during RAM_WR before ram_we cycle -> RAM unchanged, all outputs at reset values.

Source files
------------

// File: rtl/cpu_mem_bridge.sv
// CPU memory-port bridge: routes requests to a latency-L synchronous RAM or an MMIO bus.
// A flash loader may take over the RAM port. Define MEM_BRIDGE_TIMEOUT_EN to enable the MMIO timeout.

module cpu_mem_bridge #(
  parameter int          ADDR_WIDTH     = 16,
  parameter int          RAM_LATENCY    = 2,
  parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_mem_valid,
  input  logic [31:0]           cpu_mem_addr,
  input  logic [31:0]           cpu_mem_wdata,
  input  logic [3:0]            cpu_mem_wstrb,
  output logic                  cpu_mem_ready,
  output logic [31:0]           cpu_mem_rdata,
  input  logic                  flash_active,
  input  logic                  flash_wen,
  input  logic [ADDR_WIDTH-1:0] flash_addr,
  input  logic [31:0]           flash_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  mmio_valid,
  output logic [31:0]           mmio_addr,
  output logic [3:0]            mmio_wstrb,
  output logic [31:0]           mmio_wdata,
  input  logic                  mmio_ready,
  input  logic [31:0]           mmio_rdata,
  output logic                  bus_error
);

  // Handshake: cpu_mem_valid is sampled only in IDLE while flash_active is low; the request
  // completes with a single-cycle cpu_mem_ready. mmio_valid stays high with stable
  // address/data/strobes until the cycle mmio_ready is sampled high.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAM_RD    = 3'd1,
    RAM_WR    = 3'd2,
    MMIO_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RAM_LATENCY);

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic [3:0]            ram_we_q, ram_we_d;
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mmio_valid_q, mmio_valid_d;
  logic [31:0]           mmio_addr_q, mmio_addr_d;
  logic [31:0]           mmio_wdata_q, mmio_wdata_d;
  logic [3:0]            mmio_wstrb_q, mmio_wstrb_d;
  logic [2:0]            lat_cnt, lat_cnt_d;
  logic                  is_mmio;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int            TW      = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt, to_cnt_d;
  logic          bus_error_q, bus_error_d;
`endif

  assign is_mmio = (cpu_mem_addr >= MMIO_BASE);

  always_comb begin
    state_d      = state;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = 4'b0000;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    mmio_valid_d = mmio_valid_q;
    mmio_addr_d  = mmio_addr_q;
    mmio_wdata_d = mmio_wdata_q;
    mmio_wstrb_d = mmio_wstrb_q;
    lat_cnt_d    = lat_cnt;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    to_cnt_d     = to_cnt;
    bus_error_d  = bus_error_q;
`endif

    case (state)
      IDLE: begin
        lat_cnt_d = '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        if (cpu_mem_valid && !flash_active) begin
          if (is_mmio) begin
            mmio_valid_d = 1'b1;
            mmio_addr_d  = cpu_mem_addr;
            mmio_wdata_d = cpu_mem_wdata;
            mmio_wstrb_d = cpu_mem_wstrb;
            state_d      = MMIO_WAIT;
          end else begin
            // Upper address bits above the RAM index are ignored, so RAM aliases.
            ram_addr_d  = cpu_mem_addr[ADDR_WIDTH+1:2];
            ram_wdata_d = cpu_mem_wdata;
            if (cpu_mem_wstrb != 4'b0000) begin
              ram_we_d = cpu_mem_wstrb;
              state_d  = RAM_WR;
            end else begin
              state_d  = RAM_RD;
            end
          end
        end
      end

      RAM_WR: begin
        // While the loader owns the port the CPU write never reaches the RAM.
        if (flash_active) begin
          state_d = IDLE;
        end else begin
          ready_d = 1'b1;
          state_d = RESP;
        end
      end

      RAM_RD: begin
        if (flash_active) begin
          lat_cnt_d = '0;
          state_d   = IDLE;
        end else if (lat_cnt == LAT_LAST) begin
          rdata_d = ram_rdata;
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt + 3'd1;
        end
      end

      MMIO_WAIT: begin
        if (mmio_ready) begin
          rdata_d      = mmio_rdata;
          mmio_valid_d = 1'b0;
          ready_d      = 1'b1;
          state_d      = RESP;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          rdata_d      = 32'hDEAD_BEEF;
          mmio_valid_d = 1'b0;
          ready_d      = 1'b1;
          bus_error_d  = 1'b1;
          state_d      = RESP;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= '0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      mmio_valid_q <= 1'b0;
      mmio_addr_q  <= '0;
      mmio_wdata_q <= '0;
      mmio_wstrb_q <= '0;
      lat_cnt      <= '0;
    end else begin
      state        <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      mmio_valid_q <= mmio_valid_d;
      mmio_addr_q  <= mmio_addr_d;
      mmio_wdata_q <= mmio_wdata_d;
      mmio_wstrb_q <= mmio_wstrb_d;
      lat_cnt      <= lat_cnt_d;
    end
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      to_cnt      <= to_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

  // The loader overrides the RAM port combinationally whenever it is active.
  assign ram_addr  = flash_active ? flash_addr      : ram_addr_q;
  assign ram_wdata = flash_active ? flash_data      : ram_wdata_q;
  assign ram_we    = flash_active ? {4{flash_wen}}  : ram_we_q;

  assign cpu_mem_ready = ready_q;
  assign cpu_mem_rdata = rdata_q;
  assign mmio_valid    = mmio_valid_q;
  assign mmio_addr     = mmio_addr_q;
  assign mmio_wstrb    = mmio_wstrb_q;
  assign mmio_wdata    = mmio_wdata_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed plus randomized bench for cpu_mem_bridge against a word-array RAM model
// and a transaction-level reference memory.

module tb_cpu_mem_bridge;

  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  localparam int TO    = 8;

  logic          clk;
  logic          rst_n;
  logic          cpu_mem_valid;
  logic [31:0]   cpu_mem_addr;
  logic [31:0]   cpu_mem_wdata;
  logic [3:0]    cpu_mem_wstrb;
  logic          cpu_mem_ready;
  logic [31:0]   cpu_mem_rdata;
  logic          flash_active;
  logic          flash_wen;
  logic [AW-1:0] flash_addr;
  logic [31:0]   flash_data;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          mmio_valid;
  logic [31:0]   mmio_addr;
  logic [3:0]    mmio_wstrb;
  logic [31:0]   mmio_wdata;
  logic          mmio_ready;
  logic [31:0]   mmio_rdata;
  logic          bus_error;

  int vectors;
  int miscompares;

  cpu_mem_bridge #(
    .ADDR_WIDTH(AW), .RAM_LATENCY(LAT), .MMIO_BASE(32'h8000_0000), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
    .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
    .flash_active(flash_active), .flash_wen(flash_wen),
    .flash_addr(flash_addr), .flash_data(flash_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .mmio_valid(mmio_valid), .mmio_addr(mmio_addr), .mmio_wstrb(mmio_wstrb),
    .mmio_wdata(mmio_wdata), .mmio_ready(mmio_ready), .mmio_rdata(mmio_rdata),
    .bus_error(bus_error)
  );

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM device: byte-enable writes, read data appears LAT cycles after the address.
  logic [31:0] ram_mem [DEPTH];
  logic [31:0] ram_pipe [LAT];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end

  assign ram_rdata = ram_pipe[LAT-1];

  // MMIO device: answers on the mmio_delay-th cycle of a request and watches stability.
  int          mmio_delay;
  logic [31:0] mmio_resp;
  int          mmio_cycles;
  logic        mmio_unstable;
  logic [31:0] mmio_a0, mmio_w0;
  logic [3:0]  mmio_s0;

  initial begin
    mmio_ready    = 1'b0;
    mmio_rdata    = '0;
    mmio_cycles   = 0;
    mmio_unstable = 1'b0;
    mmio_a0       = '0;
    mmio_w0       = '0;
    mmio_s0       = '0;
    forever begin
      @(negedge clk);
      if (mmio_valid && !mmio_ready) begin
        if (mmio_cycles == 0) begin
          mmio_a0 = mmio_addr;
          mmio_w0 = mmio_wdata;
          mmio_s0 = mmio_wstrb;
        end else if (mmio_addr !== mmio_a0 || mmio_wdata !== mmio_w0 || mmio_wstrb !== mmio_s0) begin
          mmio_unstable = 1'b1;
        end
        mmio_cycles = mmio_cycles + 1;
        if (mmio_cycles == mmio_delay) begin
          mmio_ready = 1'b1;
          mmio_rdata = mmio_resp;
        end
      end else begin
        mmio_ready    = 1'b0;
        mmio_cycles   = 0;
        mmio_unstable = 1'b0;
      end
    end
  end

  // Scoreboard: reference memory updated at transaction level.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];

  function automatic int unsigned word_of(input logic [31:0] addr);
    return (addr / 4) % DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},      {31'd0, cpu_mem_ready}, 32'd0);
    chk({tag, "_rdata"},      cpu_mem_rdata,          32'd0);
    chk({tag, "_ram_we"},     {28'd0, ram_we},        32'd0);
    chk({tag, "_ram_addr"},   {24'd0, ram_addr},      32'd0);
    chk({tag, "_ram_wdata"},  ram_wdata,              32'd0);
    chk({tag, "_mmio_valid"}, {31'd0, mmio_valid},    32'd0);
    chk({tag, "_mmio_addr"},  mmio_addr,              32'd0);
    chk({tag, "_mmio_wstrb"}, {28'd0, mmio_wstrb},    32'd0);
    chk({tag, "_mmio_wdata"}, mmio_wdata,             32'd0);
    chk({tag, "_bus_error"},  {31'd0, bus_error},     32'd0);
  endtask

  // Driver: one CPU transaction, checked against the reference model.
  task automatic cpu_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic        to_mmio;
    int          exp_lat;
    int          lat;
    logic [31:0] exp_data;
    to_mmio = (addr >= 32'h8000_0000);
    exp_lat = to_mmio ? mmio_delay : ((strb != 4'd0) ? 1 : LAT + 1);
    if (!to_mmio && strb == 4'd0) exp_q.push_back(ref_mem[word_of(addr)]);
    if (to_mmio && strb == 4'd0) exp_q.push_back(mmio_resp);

    @(negedge clk);
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = addr;
    cpu_mem_wdata = wdata;
    cpu_mem_wstrb = strb;
    @(posedge clk);
    #1;
    cpu_mem_valid = 1'b0;
    cpu_mem_wstrb = 4'd0;
    if (to_mmio) begin
      chk("mmio_valid_issue", {31'd0, mmio_valid}, 32'd1);
      chk("mmio_addr_issue",  mmio_addr,           addr);
      chk("mmio_wstrb_issue", {28'd0, mmio_wstrb}, {28'd0, strb});
      if (strb != 4'd0) chk("mmio_wdata_issue", mmio_wdata, wdata);
    end else if (strb != 4'd0) begin
      chk("ram_we_issue",    {28'd0, ram_we},   {28'd0, strb});
      chk("ram_addr_issue",  {24'd0, ram_addr}, word_of(addr));
      chk("ram_wdata_issue", ram_wdata,         wdata);
    end else begin
      chk("ram_we_read", {28'd0, ram_we}, 32'd0);
    end

    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!to_mmio && strb != 4'd0 && lat == 1) chk("ram_we_one_cycle", {28'd0, ram_we}, 32'd0);
    end while (!cpu_mem_ready && lat < 40);
    chk("latency", lat, exp_lat);
    if (to_mmio) begin
      chk("mmio_valid_cycles", mmio_cycles, mmio_delay);
      chk("mmio_stable", {31'd0, mmio_unstable}, 32'd0);
      chk("mmio_valid_dropped", {31'd0, mmio_valid}, 32'd0);
    end
    if (strb == 4'd0 && exp_q.size() > 0) begin
      exp_data = exp_q.pop_front();
      chk(to_mmio ? "mmio_rdata" : "ram_rdata", cpu_mem_rdata, exp_data);
    end
    if (!to_mmio && strb != 4'd0)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[word_of(addr)][8*b +: 8] = wdata[8*b +: 8];

    @(posedge clk);
    #1;
    chk("ready_single_pulse", {31'd0, cpu_mem_ready}, 32'd0);
  endtask

  initial begin
    int          rdy_cnt;
    int          lat;
    logic [31:0] fdata;
    logic [31:0] a;
    int          kind;

    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    cpu_mem_valid = 1'b0;
    cpu_mem_addr  = '0;
    cpu_mem_wdata = '0;
    cpu_mem_wstrb = '0;
    flash_active  = 1'b0;
    flash_wen     = 1'b0;
    flash_addr    = '0;
    flash_data    = '0;
    mmio_delay    = 1;
    mmio_resp     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Flash loader fills the whole RAM through the combinational override
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      flash_active = 1'b1;
      flash_wen    = 1'b1;
      flash_addr   = AW'(i);
      flash_data   = $urandom;
      ref_mem[i]   = flash_data;
      if (i < 2) begin
        #1;
        chk("flash_ram_we",    {28'd0, ram_we},   32'hF);
        chk("flash_ram_addr",  {24'd0, ram_addr}, i);
        chk("flash_ram_wdata", ram_wdata,         flash_data);
      end
    end
    @(negedge clk);
    flash_active = 1'b0;
    flash_wen    = 1'b0;

    // Byte-strobe write over a known word, then readback
    cpu_xfer(32'h0000_0010, 32'h1122_3344, 4'b1111);
    cpu_xfer(32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
    cpu_xfer(32'h0000_0010, 32'h0, 4'b0000);
    chk("strobe_readback_const", cpu_mem_rdata, 32'h11BB_33DD);

    // Aliasing: upper address bits ignored
    cpu_xfer(32'h0012_3408, 32'hCAFE_F00D, 4'b1111);
    cpu_xfer(32'h0000_0008, 32'h0, 4'b0000);
    chk("alias_const", cpu_mem_rdata, 32'hCAFE_F00D);

    // MMIO read with 5-cycle device latency
    mmio_delay = 5;
    mmio_resp  = 32'h0000_1234;
    cpu_xfer(32'h8000_0004, 32'h0, 4'b0000);
    chk("mmio_read_const", cpu_mem_rdata, 32'h0000_1234);

    // CPU request while the loader is active is ignored
    @(negedge clk);
    flash_active  = 1'b1;
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = 32'h0000_0020;
    @(negedge clk);
    cpu_mem_valid = 1'b0;
    rdy_cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (cpu_mem_ready) rdy_cnt++;
    end
    flash_active = 1'b0;
    chk("no_accept_while_flash", rdy_cnt, 0);

    // Loader takes over during RAM_RD: read aborts, loader write to word 7 lands
    @(negedge clk);
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = 32'h0000_0050;
    cpu_mem_wstrb = 4'b0000;
    @(posedge clk);
    #1;
    cpu_mem_valid = 1'b0;
    @(posedge clk);
    #1;
    fdata        = $urandom;
    flash_active = 1'b1;
    flash_wen    = 1'b1;
    flash_addr   = AW'(7);
    flash_data   = fdata;
    ref_mem[7]   = fdata;
    #1;
    chk("abort_flash_we",   {28'd0, ram_we},   32'hF);
    chk("abort_flash_addr", {24'd0, ram_addr}, 32'd7);
    rdy_cnt = 0;
    @(posedge clk);
    #1;
    flash_wen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (cpu_mem_ready) rdy_cnt++;
    end
    flash_active = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (cpu_mem_ready) rdy_cnt++;
    end
    chk("abort_no_ready", rdy_cnt, 0);
    cpu_xfer(32'h0000_0050, 32'h0, 4'b0000);
    cpu_xfer(32'h0000_001C, 32'h0, 4'b0000);
    chk("flash_word7", cpu_mem_rdata, fdata);

    // Randomized mix of RAM and MMIO traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      mmio_delay = $urandom_range(1, 6);
      mmio_resp  = $urandom;
      a = $urandom;
      if (kind < 2) a[31] = 1'b0;
      else          a[31] = 1'b1;
      if (kind == 1 || kind == 3) cpu_xfer(a, $urandom, 4'($urandom_range(1, 15)));
      else                        cpu_xfer(a, $urandom, 4'b0000);
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // Silent MMIO device: timeout answers DEADBEEF and sets sticky bus_error
    mmio_delay = 100000;
    @(negedge clk);
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = 32'h8000_0100;
    cpu_mem_wstrb = 4'b0000;
    @(posedge clk);
    #1;
    cpu_mem_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cpu_mem_ready && lat < 40);
    chk("timeout_latency", lat, TO + 1);
    chk("timeout_rdata", cpu_mem_rdata, 32'hDEAD_BEEF);
    chk("timeout_bus_error", {31'd0, bus_error}, 32'd1);
    chk("timeout_valid_dropped", {31'd0, mmio_valid}, 32'd0);
    @(posedge clk);
    #1;
    mmio_delay = 2;
    cpu_xfer(32'h0000_0030, 32'h0, 4'b0000);
    chk("bus_error_sticky", {31'd0, bus_error}, 32'd1);
`else
    chk("bus_error_tied", {31'd0, bus_error}, 32'd0);
`endif

    // Reset in RAM_WR before the write edge: no write, outputs cleared
    @(negedge clk);
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = 32'h0000_0040;
    cpu_mem_wdata = ~ref_mem[16];
    cpu_mem_wstrb = 4'b1111;
    @(posedge clk);
    #1;
    cpu_mem_valid = 1'b0;
    cpu_mem_wstrb = 4'b0000;
    chk("pre_reset_ram_we", {28'd0, ram_we}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    rdy_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (cpu_mem_ready) rdy_cnt++;
    end
    chk("midreset_no_ready", rdy_cnt, 0);
    cpu_xfer(32'h0000_0040, 32'h0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
